// File: rtl/seg_pkg.sv
// Shared seven-segment definitions for the scan driver.
// Segment bytes are active-low {a,b,c,d,e,f,g,dp}, matching the board table.
package seg_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Hex-to-segment codes with dp off; entry 0 is the rightmost byte.
   localparam logic [15:0][7:0] HEX_SEG = {
      8'h71, 8'h61, 8'h85, 8'h63,    // F E d C
      8'hC1, 8'h11, 8'h09, 8'h01,    // b A 9 8
      8'h1F, 8'h41, 8'h49, 8'h99,    // 7 6 5 4
      8'h0D, 8'h25, 8'h9F, 8'h03     // 3 2 1 0
   };

   // Segment byte for a nibble; dp=1 lights the decimal point.
   function automatic logic [7:0] hex2seg(input logic [3:0] nibble, input logic dp);
      logic [7:0] code;
      code = HEX_SEG[nibble];
      return {code[7:1], ~dp};
   endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Bus bundle between the debug mux and the scan driver.
//   data_in/dp_in/blink_mask/load : value to display and its capture strobe
//   blank_lz                       : live leading-zero blanking enable
//   ready                          : no captured value awaiting commit
//   AN/seg/frame_tick              : board pins and frame-end pulse
interface seg_scan_driver_if #(
   parameter int unsigned DIGITS = 8
);
   logic [4*DIGITS-1:0] data_in;
   logic [DIGITS-1:0]   dp_in;
   logic [DIGITS-1:0]   blink_mask;
   logic                blank_lz;
   logic                load;
   logic                ready;
   logic [DIGITS-1:0]   AN;
   logic [7:0]          seg;
   logic                frame_tick;

   modport master (
      output data_in, dp_in, blink_mask, blank_lz, load,
      input  ready, AN, seg, frame_tick
   );

   modport slave (
      input  data_in, dp_in, blink_mask, blank_lz, load,
      output ready, AN, seg, frame_tick
   );
endinterface

// File: rtl/seg_tick_gen.sv
// Refresh divider: pulses slot_tick once every DIV clocks.
//   clk_in, rst : clock, async active-high reset
//   slot_tick   : high on the last cycle of each digit slot
module seg_tick_gen #(
   parameter int unsigned DIV = 2000
) (
   input  logic clk_in,
   input  logic rst,
   output logic slot_tick
);
   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   assign slot_tick = (cnt == CW'(DIV - 1));

   // Free-running 0..DIV-1 counter
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst)            cnt <= '0;
      else if (slot_tick) cnt <= '0;
      else                cnt <= cnt + CW'(1);
   end
endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-aligned (tear-free) commit.
//   clk_in, rst : clock, async active-high reset
//   bus (slave) : load/ready capture of data/dp/blink, blank_lz, AN, seg, frame_tick
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int unsigned DIGITS       = 8,
   parameter int unsigned DIV          = 2000,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input  logic                      clk_in,
   input  logic                      rst,
   seg_scan_driver_if.slave          bus
);
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int unsigned DW = 4 * DIGITS;

   logic              slot_tick;
   logic              frame_end;
   logic              commit;
   logic [IW-1:0]     idx;
   logic [IW-1:0]     idx_nxt;

   logic              pend;
   logic [DW-1:0]     pend_data;
   logic [DIGITS-1:0] pend_dp;
   logic [DIGITS-1:0] pend_blink;

   logic [DW-1:0]     act_data,  act_data_nxt;
   logic [DIGITS-1:0] act_dp,    act_dp_nxt;
   logic [DIGITS-1:0] act_blink, act_blink_nxt;

   logic [BW-1:0]     bcnt;
   logic              bphase, bphase_nxt;

   logic [3:0]        nib;
   logic              nib_dp;
   logic              nib_blink;
   logic              upper_zero;
   logic              lz_blank;
   logic              blink_off;
   logic [DIGITS-1:0] an_nxt;
   logic [7:0]        seg_nxt;

   seg_tick_gen #(.DIV(DIV)) u_tick (
      .clk_in    (clk_in),
      .rst       (rst),
      .slot_tick (slot_tick)
   );

   assign frame_end      = slot_tick && (idx == IW'(DIGITS - 1));
   assign commit         = frame_end && pend;
   assign idx_nxt        = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
   assign bus.ready      = ~pend;
   assign bus.frame_tick = frame_end;

   // Values the active set and blink phase hold after this edge; the first
   // digit of a new frame already uses them so a frame never mixes values.
   assign act_data_nxt  = commit ? pend_data  : act_data;
   assign act_dp_nxt    = commit ? pend_dp    : act_dp;
   assign act_blink_nxt = commit ? pend_blink : act_blink;
   assign bphase_nxt    = (frame_end && (bcnt == BW'(BLINK_FRAMES - 1))) ? ~bphase : bphase;

   // Select the next digit and decide whether it is blanked
   always_comb begin
      nib        = 4'h0;
      nib_dp     = 1'b0;
      nib_blink  = 1'b0;
      an_nxt     = '1;
      upper_zero = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (IW'(i) == idx_nxt) begin
            nib       = act_data_nxt[4*i +: 4];
            nib_dp    = act_dp_nxt[i];
            nib_blink = act_blink_nxt[i];
            an_nxt[i] = 1'b0;
         end
         if ((IW'(i) >= idx_nxt) && (act_data_nxt[4*i +: 4] != 4'h0))
            upper_zero = 1'b0;
      end
      lz_blank  = bus.blank_lz && (idx_nxt != '0) && upper_zero;
      blink_off = nib_blink && !bphase_nxt;
      // Blink-off hides the decimal point too; leading-zero blanking keeps it
      seg_nxt   = hex2seg(nib, nib_dp && !blink_off);
      if (lz_blank || blink_off)
         seg_nxt[7:1] = SEG_BLANK[7:1];
   end

   // Pending/active register sets and capture handshake
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         pend       <= 1'b0;
         pend_data  <= '0;
         pend_dp    <= '0;
         pend_blink <= '0;
         act_data   <= '0;
         act_dp     <= '0;
         act_blink  <= '0;
      end else begin
         act_data  <= act_data_nxt;
         act_dp    <= act_dp_nxt;
         act_blink <= act_blink_nxt;
         if (bus.load) begin
            pend       <= 1'b1;
            pend_data  <= bus.data_in;
            pend_dp    <= bus.dp_in;
            pend_blink <= bus.blink_mask;
         end else if (commit) begin
            pend <= 1'b0;
         end
      end
   end

   // Digit scan, blink phase and registered pin outputs
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         idx     <= IW'(DIGITS - 1);
         bcnt    <= '0;
         bphase  <= 1'b1;
         bus.AN  <= '1;
         bus.seg <= SEG_BLANK;
      end else begin
         bphase <= bphase_nxt;
         if (frame_end)
            bcnt <= (bcnt == BW'(BLINK_FRAMES - 1)) ? '0 : bcnt + BW'(1);
         if (slot_tick) begin
            idx     <= idx_nxt;
            bus.AN  <= an_nxt;
            bus.seg <= seg_nxt;
         end
      end
   end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (DIGITS=4, DIV=4, BLINK_FRAMES=2).
module tb_seg_scan_driver;
   localparam int unsigned DIGITS = 4;
   localparam int unsigned DIV    = 4;
   localparam int unsigned BF     = 2;

   logic clk_in = 1'b0;
   logic rst    = 1'b1;
   always #5 clk_in = ~clk_in;

   seg_scan_driver_if #(.DIGITS(DIGITS)) bus ();

   seg_scan_driver #(.DIGITS(DIGITS), .DIV(DIV), .BLINK_FRAMES(BF)) u_dut (
      .clk_in (clk_in),
      .rst    (rst),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Segment glyphs with dp off, written from the segment drawings
   function automatic logic [7:0] ref_code(input logic [3:0] v);
      case (v)
         4'h0: return 8'b0000_0011;  4'h1: return 8'b1001_1111;
         4'h2: return 8'b0010_0101;  4'h3: return 8'b0000_1101;
         4'h4: return 8'b1001_1001;  4'h5: return 8'b0100_1001;
         4'h6: return 8'b0100_0001;  4'h7: return 8'b0001_1111;
         4'h8: return 8'b0000_0001;  4'h9: return 8'b0000_1001;
         4'hA: return 8'b0001_0001;  4'hB: return 8'b1100_0001;
         4'hC: return 8'b0110_0011;  4'hD: return 8'b1000_0101;
         4'hE: return 8'b0110_0001;  default: return 8'b0111_0001;
      endcase
   endfunction

   // Reference model: cycle/slot/frame counting since reset
   int         m_t, m_j, m_frames;
   logic [15:0] m_act, m_pdata;
   logic [3:0]  m_adp, m_ablk, m_pdp, m_pblk;
   bit          m_pend;
   logic [3:0]  m_an;
   logic [7:0]  m_seg;

   always @(posedge clk_in or posedge rst) begin
      bit tick, fe, vis, boff, lz;
      int n;
      if (rst) begin
         m_t = 0; m_j = 0; m_frames = 0;
         m_act = '0; m_adp = '0; m_ablk = '0;
         m_pdata = '0; m_pdp = '0; m_pblk = '0; m_pend = 1'b0;
         m_an = 4'hF; m_seg = 8'hFF;
      end else begin
         tick = ((m_t % DIV) == DIV - 1);
         fe   = tick && ((m_j % DIGITS) == 0);
         if (fe) begin
            m_frames++;
            if (m_pend) begin
               m_act = m_pdata; m_adp = m_pdp; m_ablk = m_pblk; m_pend = 1'b0;
            end
         end
         if (bus.load) begin
            m_pdata = bus.data_in; m_pdp = bus.dp_in; m_pblk = bus.blink_mask; m_pend = 1'b1;
         end
         if (tick) begin
            n    = m_j % DIGITS;
            vis  = ((m_frames / BF) % 2) == 0;
            boff = m_ablk[n] && !vis;
            lz   = bus.blank_lz && (n != 0) && ((m_act >> (4 * n)) == 16'h0);
            m_an = 4'hF;
            m_an[n] = 1'b0;
            m_seg = ref_code(4'((m_act >> (4 * n)) & 16'hF));
            if (boff || lz) m_seg[7:1] = 7'h7F;
            m_seg[0] = boff || !m_adp[n];
            m_j++;
         end
         m_t++;
      end
   end

   // Continuous comparison against the model, mid-cycle
   always @(negedge clk_in) begin
      if (chk_en) begin
         check("model_an",    32'(bus.AN),         32'(m_an));
         check("model_seg",   32'(bus.seg),        32'(m_seg));
         check("model_ready", 32'(bus.ready),      32'(!m_pend));
         check("model_ftick", 32'(bus.frame_tick),
               32'(!rst && ((m_t % DIV) == DIV - 1) && ((m_j % DIGITS) == 0)));
      end
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bm);
      bus.data_in = d; bus.dp_in = dp; bus.blink_mask = bm; bus.load = 1'b1;
      step();
      bus.load = 1'b0;
   endtask

   // Leaves the phase such that the next edge is a frame end
   task automatic wait_ft(input string name);
      int k;
      k = 0;
      while (!bus.frame_tick && k < 100) begin
         step();
         k++;
      end
      if (!bus.frame_tick) begin
         checks++; errors++;
         $display("FAIL %s: frame_tick timeout got 0 expected 1", name);
      end
   endtask

   task automatic capture(output logic [31:0] segs);
      logic [3:0] one, mask;
      one = 4'b0001;
      wait_ft("capture");
      step();
      segs = '1;
      for (int d = 0; d < DIGITS; d++) begin
         mask = ~(one << d);
         check("scan_an", 32'(bus.AN), 32'(mask));
         segs[8*d +: 8] = bus.seg;
         repeat (DIV) step();
      end
   endtask

   typedef struct {
      logic [15:0] data;
      logic [3:0]  dp;
      logic        blz;
      logic [31:0] exp;   // {digit3, digit2, digit1, digit0}
   } vec_t;

   initial begin
      vec_t        vecs[5];
      logic [31:0] segs;
      logic [7:0]  bs[8];
      logic [7:0]  other;
      int          k;

      vecs[0] = '{16'h1A2F, 4'b0000, 1'b0, 32'h9F11_2571};
      vecs[1] = '{16'h0050, 4'b0100, 1'b1, 32'hFFFE_4903};
      vecs[2] = '{16'h0000, 4'b0000, 1'b1, 32'hFFFF_FF03};
      vecs[3] = '{16'hBEEF, 4'b1111, 1'b0, 32'hC060_6070};
      vecs[4] = '{16'h0800, 4'b0001, 1'b1, 32'hFF01_0302};

      bus.data_in = '0; bus.dp_in = '0; bus.blink_mask = '0;
      bus.blank_lz = 1'b0; bus.load = 1'b0;

      // Reset values while held
      rst = 1'b1;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      check("rst_an",    32'(bus.AN),         32'hF);
      check("rst_seg",   32'(bus.seg),        32'hFF);
      check("rst_ready", 32'(bus.ready),      32'h1);
      check("rst_ftick", 32'(bus.frame_tick), 32'h0);
      rst = 1'b0;
      chk_en = 1'b1;

      // First slot change lands on the fourth edge
      repeat (3) step();
      check("first_hold_an", 32'(bus.AN), 32'hF);
      step();
      check("first_an",  32'(bus.AN),  32'hE);
      check("first_seg", 32'(bus.seg), 32'h03);

      // Table-driven digit patterns
      for (int i = 0; i < 5; i++) begin
         bus.blank_lz = vecs[i].blz;
         do_load(vecs[i].data, vecs[i].dp, 4'b0000);
         check($sformatf("vec%0d_ready", i), 32'(bus.ready), 32'h0);
         wait_ft("vec_commit");
         step();
         capture(segs);
         for (int d = 0; d < DIGITS; d++)
            check($sformatf("vec%0d_d%0d", i, d), 32'(segs[8*d +: 8]), 32'(vecs[i].exp[8*d +: 8]));
      end

      // Frame period
      bus.blank_lz = 1'b0;
      wait_ft("period_a");
      step();
      k = 1;
      while (!bus.frame_tick && k < 100) begin
         step();
         k++;
      end
      check("frame_period", 32'(k), 32'd16);

      // Tear-free commit: old value holds until the frame end
      do_load(16'h1A2F, 4'b0000, 4'b0000);
      wait_ft("tear_a");
      step();
      repeat (5) step();
      do_load(16'h1234, 4'b0000, 4'b0000);
      check("tear_ready_low", 32'(bus.ready), 32'h0);
      wait_ft("tear_b");
      check("tear_old_an",  32'(bus.AN),    32'h7);
      check("tear_old_seg", 32'(bus.seg),   32'h9F);
      check("tear_pending", 32'(bus.ready), 32'h0);
      step();
      check("tear_ready_high", 32'(bus.ready), 32'h1);
      check("tear_new_seg",    32'(bus.seg),   32'h99);

      // Coincident load on the frame-end edge
      do_load(16'h0000, 4'b0000, 4'b0000);
      wait_ft("coin_a");
      step();
      repeat (6) step();
      do_load(16'h1234, 4'b0000, 4'b0000);
      wait_ft("coin_b");
      do_load(16'hBEEF, 4'b0000, 4'b0000);
      check("coin_ready", 32'(bus.ready), 32'h0);
      check("coin_seg",   32'(bus.seg),   32'h99);
      wait_ft("coin_c");
      step();
      check("coin_ready2", 32'(bus.ready), 32'h1);
      check("coin_seg2",   32'(bus.seg),   32'h71);

      // Blink on digit 0 with a two-frame half-period
      do_load(16'h1A2F, 4'b0000, 4'b0001);
      wait_ft("blink_a");
      step();
      for (int f = 0; f < 8; f++) begin
         wait_ft("blink_f");
         step();
         bs[f] = bus.seg;
      end
      for (int f = 0; f < 6; f++) begin
         check("blink_code", 32'((bs[f] == 8'h71) || (bs[f] == 8'hFF)), 32'h1);
         other = (bs[f] == 8'h71) ? 8'hFF : 8'h71;
         check("blink_alt", 32'(bs[f+2]), 32'(other));
      end

      // Randomized traffic against the model
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(7) == 0) begin
            bus.data_in    = 16'($urandom);
            bus.dp_in      = 4'($urandom);
            bus.blink_mask = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
            bus.load       = 1'b1;
         end else begin
            bus.load = 1'b0;
         end
         if ($urandom_range(31) == 0) bus.blank_lz = ~bus.blank_lz;
         if ($urandom_range(15) == 0) bus.data_in[15:8] = 8'h00;
         step();
      end
      bus.load = 1'b0;

      // Async reset mid-slot with a value pending
      do_load(16'hABCD, 4'b1111, 4'b0000);
      check("prereset_pending", 32'(bus.ready), 32'h0);
      @(negedge clk_in);
      #2 rst = 1'b1;
      #1;
      check("midrst_an",    32'(bus.AN),         32'hF);
      check("midrst_seg",   32'(bus.seg),        32'hFF);
      check("midrst_ready", 32'(bus.ready),      32'h1);
      check("midrst_ftick", 32'(bus.frame_tick), 32'h0);
      #1 rst = 1'b0;
      repeat (4) step();
      check("postrst_an",    32'(bus.AN),    32'hE);
      check("postrst_seg",   32'(bus.seg),   32'h03);
      check("postrst_ready", 32'(bus.ready), 32'h1);
      repeat (20) step();

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised multiplexed seven-segment scan driver, successor to the fixed 8-digit display path of the single-cycle CPU board top. It latches a displayed word through a load/ready handshake and commits it only at frame boundaries, so the display never tears. It scans `DIGITS` common-anode digits at a programmable refresh rate, with per-digit decimal points, leading-zero blanking and per-digit blink. It sits between the CPU debug mux (rd_data / Inst_code / PC) and the board AN/seg pins.

## Interface
- `DIGITS`, 8: number of digits scanned, legal range 1..16.
- `DIV`, 2000: system clocks per digit slot, ≥2.
- `BLINK_FRAMES`, 64: full scan frames per blink half-period, ≥1.
- `clk_in` input 1: system clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `data_in` input 4*DIGITS: hex nibbles; nibble i is digit i, digit 0 is the least significant.
- `dp_in` input DIGITS: per-digit decimal point enable.
- `blink_mask` input DIGITS: per-digit blink enable.
- `blank_lz` input 1: leading-zero blanking enable; level, sampled live.
- `load` input 1: one-cycle strobe that captures `data_in`, `dp_in` and `blink_mask`.
- `ready` output 1: high when no captured value is awaiting commit.
- `AN` output DIGITS: active-low digit enables; exactly one is low after the first slot.
- `seg` output 8: active-low segments {a,b,c,d,e,f,g,dp} as [7:0]. Hex 0 = 8'b00000011; digit codes match the existing board table.
- `frame_tick` output 1: one-cycle pulse at each frame end.

## Operation
- Divider `cnt` counts 0..DIV-1. `slot_tick` is asserted when cnt==DIV-1, and cnt wraps to 0 on that cycle.
- Digit index `idx` advances on `slot_tick`: DIGITS-1 → 0, otherwise +1. A frame end is `slot_tick` with idx==DIGITS-1, and it drives `frame_tick` combinationally.
- Two register sets:
  - pending: data, dp, blink, plus a `pend` flag.
  - active: data, dp, blink.
- `ready` = ~pend.
- On `load`, the pending regs take the inputs and `pend` is set to 1. A `load` while pend=1 overwrites the pending regs (last write wins).
- At frame end with pend=1:
  - active takes the pending contents as they were before that edge.
  - pend clears, unless `load` is also high that cycle. In that case the pending regs take the new inputs and pend stays 1.
- Blink: `bcnt` counts frame ends 0..BLINK_FRAMES-1. On wrap, `bphase` toggles; `bphase`=1 means visible.
- Digit output on `slot_tick` for the next index n:
  - AN: bit n low, all other bits high.
  - Blanked when `blank_lz`=1, n≠0, and active nibbles n..DIGITS-1 are all zero.
  - Blanked when blink[n]=1 and bphase=0.
  - A blanked digit drives segments a–g as 1.
  - The dp bit = ~dp[n], except that blink-off also forces dp to 1.

## Timing
- Reset values:
  - cnt=0, idx=DIGITS-1 (the first tick selects digit 0).
  - AN all 1, seg 8'hFF, frame_tick=0.
  - All active and pending regs 0, pend=0, ready=1.
  - bcnt=0, bphase=1.
- AN and seg are registered: they change on the clock edge at which `slot_tick` is high, and hold for DIV cycles.
- `ready` falls on the edge after `load`. It rises on the edge where the commit happens.
- Worst-case load-to-display latency is DIGITS*DIV + DIV cycles.
- `rst` mid-frame or mid-pending immediately restores all reset values and discards any pending value.
- DIGITS=1: every slot_tick is a frame end, and AN stays at 0 after the first tick.

## Structure
- Shared package `seg_pkg` holds:
  - the 16-entry hex→segment constant table;
  - `SEG_BLANK` = 8'hFF;
  - function `hex2seg(nibble, dp)`.
- Sub-module `seg_tick_gen` (param DIV, outputs slot_tick) holds the divider. It replaces the current hard-coded refresh divider.
- Everything else lives in `seg_scan_driver`.

## Test plan
- Reset values: with DIGITS=4, DIV=4, hold rst → AN=4'b1111, seg=8'hFF, ready=1. After release, first change at cycle 4: AN=4'b1110, seg=8'b00000011.
- Scan order: load data 16'h1A2F → digit 0..3 show 8'b01110001, 00100101, 00010001, 10011111. frame_tick pulses every 16 cycles.
- Tear-free commit: load 16'h1234 mid-frame → ready=0, old value persists to frame end. Commit on that edge, ready=1.
- Coincident events: load 16'hBEEF on the frame-end cycle while 16'h1234 is pending → 1234 displayed and ready stays 0. BEEF commits at the next frame end.
- Blanking: blank_lz=1, data 16'h0050, dp_in=4'b0100 → digits 3 and 2 blank, digit 2 seg=8'b11111110, digit 0 shows 0. data 0 shows only digit 0 as 0.
- Blink and async reset:
  - BLINK_FRAMES=2, blink_mask=4'b0001 → digit 0 alternates code/8'hFF every 2 frames.
  - rst pulse mid-slot → outputs are reset values within the same cycle.
